// File: rtl/beamscaler_bank.sv
// Per-beam trigger scaler bank: gated saturating counters, atomic snapshot, ping-pong readout RAM.
// Optional sticky saturation flag on scal_dat_o[31] when BEAMSCALER_SATURATE_FLAG_EN is defined.
module beamscaler_bank #(
  parameter int unsigned NBEAMS    = 48,
  parameter int unsigned NSCALERS  = 2,
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned ADDR_BITS = 7
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NBEAMS*NSCALERS-1:0] count_i,
  input  logic [31:0]                scal_period_i,
  input  logic                       scal_period_wr_i,
  input  logic                       scal_rd_i,
  input  logic [ADDR_BITS-1:0]       scal_adr_i,
  output logic [31:0]                scal_dat_o,
  output logic                       scal_valid_o,
  output logic                       done_o,
  output logic                       write_bank_o,
  output logic                       busy_o
);

  localparam int unsigned NCH   = NBEAMS * NSCALERS;
  localparam int unsigned DEPTH = 2 ** (ADDR_BITS + 1);
`ifdef BEAMSCALER_SATURATE_FLAG_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif
  localparam logic [31:0]          PMIN  = 32'(NCH + 2);
  localparam logic [WIDTH-1:0]     CMAX  = '1;
  localparam logic [ADDR_BITS-1:0] LAST  = ADDR_BITS'(NCH - 1);
  localparam logic [ADDR_BITS:0]   NCH_A = (ADDR_BITS + 1)'(NCH);

  typedef enum logic [1:0] {StIdle, StCopy, StFlip} state_e;

  // Async assert, sync deassert
  logic [1:0] rst_sync_q;
  logic       rst;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) rst_sync_q <= 2'b11;
    else          rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst = rst_sync_q[1];

  logic [31:0] period_q, timer_q, period_eff;
  logic        tick;

  always_comb begin
    period_eff = scal_period_i;
    if (scal_period_i != 32'd0 && scal_period_i < PMIN) period_eff = PMIN;
  end

  assign tick = (timer_q == 32'd1);

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      timer_q  <= '0;
    end else if (scal_period_wr_i) begin
      period_q <= period_eff;
      timer_q  <= period_eff;
    end else if (tick) begin
      timer_q <= period_q;
    end else if (timer_q != 32'd0) begin
      timer_q <= timer_q - 32'd1;
    end
  end

  logic [WIDTH-1:0] cnt_q     [NCH];
  logic [WIDTH-1:0] cnt_sum   [NCH];
  logic [MW-1:0]    shadow_q  [NCH];
  logic [MW-1:0]    shadow_in [NCH];

`ifdef BEAMSCALER_SATURATE_FLAG_EN
  logic sat_q [NCH];

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) sat_q[c] <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) sat_q[c] <= tick ? 1'b0 : (sat_q[c] | (cnt_sum[c] == CMAX));
    end
  end
`endif

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_sum[c] = (cnt_q[c] == CMAX) ? CMAX : cnt_q[c] + WIDTH'(count_i[c]);
`ifdef BEAMSCALER_SATURATE_FLAG_EN
      shadow_in[c] = {sat_q[c] | (cnt_sum[c] == CMAX), cnt_sum[c]};
`else
      shadow_in[c] = cnt_sum[c];
`endif
    end
  end

  // The tick-cycle event lands in the shadow, so the new window starts from zero
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]    <= '0;
        shadow_q[c] <= '0;
      end
    end else if (tick) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]    <= '0;
        shadow_q[c] <= shadow_in[c];
      end
    end else begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_sum[c];
    end
  end

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 wb_q;
  logic [1:0]           bank_valid_q;
  logic                 done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StCopy;
          idx_d   = '0;
        end
      end
      StCopy: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) state_d = StFlip;
      end
      StFlip:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      wb_q         <= 1'b0;
      bank_valid_q <= 2'b00;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= (state_q == StFlip);
      if (state_q == StFlip) begin
        bank_valid_q[wb_q] <= 1'b1;
        wb_q               <= ~wb_q;
      end
    end
  end

  logic [MW-1:0] shadow_sel;

  always_comb begin
    shadow_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (idx_q == ADDR_BITS'(c)) shadow_sel = shadow_q[c];
    end
  end

  logic [MW-1:0] mem_q [DEPTH];

  always_ff @(posedge wb_clk_i) begin
    if (state_q == StCopy) mem_q[{wb_q, idx_q}] <= shadow_sel;
  end

  logic [MW-1:0] rd_raw;
  logic [31:0]   rd_word;
  logic          adr_ok;

  always_comb begin
    rd_raw  = mem_q[{~wb_q, scal_adr_i}];
    adr_ok  = ({1'b0, scal_adr_i} < NCH_A);
    rd_word = '0;
    if (adr_ok && bank_valid_q[~wb_q]) begin
      rd_word[WIDTH-1:0] = rd_raw[WIDTH-1:0];
`ifdef BEAMSCALER_SATURATE_FLAG_EN
      rd_word[31] = rd_raw[WIDTH];
`endif
    end
  end

  logic [31:0] dat_q;
  logic        valid_q;

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      dat_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= scal_rd_i;
      if (scal_rd_i) dat_q <= rd_word;
    end
  end

  assign scal_dat_o   = dat_q;
  assign scal_valid_o = valid_q;
  assign done_o       = done_q;
  assign write_bank_o = wb_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_beamscaler_bank.sv
// Directed, table-driven bench for beamscaler_bank (NBEAMS=4, NSCALERS=2, WIDTH=8, NCH=8).
module tb_beamscaler_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  count;
  logic [31:0] period;
  logic        period_wr;
  logic        rd;
  logic [3:0]  adr;
  logic [31:0] dat;
  logic        valid, done, wbank, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef BEAMSCALER_SATURATE_FLAG_EN
  localparam logic [31:0] SAT_EXP = 32'h8000_00FF;
`else
  localparam logic [31:0] SAT_EXP = 32'h0000_00FF;
`endif

  beamscaler_bank #(
    .NBEAMS   (4),
    .NSCALERS (2),
    .WIDTH    (8),
    .ADDR_BITS(4)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .count_i         (count),
    .scal_period_i   (period),
    .scal_period_wr_i(period_wr),
    .scal_rd_i       (rd),
    .scal_adr_i      (adr),
    .scal_dat_o      (dat),
    .scal_valid_o    (valid),
    .done_o          (done),
    .write_bank_o    (wbank),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    count = '0; period = '0; period_wr = 1'b0; rd = 1'b0; adr = '0;
    step();
    step();
    check("rst_dat", dat, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_done_busy_wb", {29'h0, done, busy, wbank}, 32'h0);
    rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic write_period(input logic [31:0] p, output int w);
    period = p;
    period_wr = 1'b1;
    step();
    period_wr = 1'b0;
    w = cyc;
  endtask

  task automatic do_read(input string name, input logic [3:0] a, input logic [31:0] exp);
    adr = a;
    rd = 1'b1;
    step();
    rd = 1'b0;
    check({name, "_valid"}, {31'h0, valid}, 32'h1);
    check(name, dat, exp);
  endtask

  task automatic wait_done(input int budget, output int d);
    int n = 0;
    do begin
      step();
      n++;
    end while (!done && n < budget);
    check("done_seen", {31'h0, done}, 32'h1);
    d = cyc;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    int w, d1, d2, d3;
    vecs[0] = '{4'd0, 32'd100};
    for (int i = 1; i < 9; i++) vecs[i] = '{4'(i), 32'd0};

    // Basic window, latency and readout
    do_reset();
    write_period(32'd100, w);
    count = 8'h01;
    wait_done(200, d1);
    check("t1_done_latency", 32'(d1 - w), 32'd109);
    check("t1_wbank", {31'h0, wbank}, 32'h1);
    check("t1_busy_at_done", {31'h0, busy}, 32'h0);
    count = 8'h00;
    for (int i = 0; i < 9; i++) do_read("t1_read", vecs[i].adr, vecs[i].exp);
    step();
    check("t1_valid_drop", {31'h0, valid}, 32'h0);
    check("t1_dat_hold", dat, 32'h0);

    // Saturation and flag clear in the following window
    do_reset();
    write_period(32'd300, w);
    count = 8'h08;
    wait_until(w + 290);
    count = 8'h00;
    wait_done(100, d1);
    check("t2_done_latency", 32'(d1 - w), 32'd309);
    do_read("t2_sat", 4'd3, SAT_EXP);
    do_read("t2_other", 4'd2, 32'd0);
    wait_done(400, d2);
    do_read("t2_next_window", 4'd3, 32'd0);

    // Period clamp and bank toggling
    do_reset();
    check("t3_wbank_init", {31'h0, wbank}, 32'h0);
    write_period(32'd3, w);
    count = 8'hFF;
    do_read("t3_before_done", 4'd0, 32'd0);
    wait_done(40, d1);
    check("t3_first_done", 32'(d1 - w), 32'd19);
    check("t3_wbank1", {31'h0, wbank}, 32'h1);
    do_read("t3_first_window", 4'd0, 32'd10);
    check("t3_done_pulse", {31'h0, done}, 32'h0);
    wait_done(40, d2);
    check("t3_interval1", 32'(d2 - d1), 32'd10);
    check("t3_wbank2", {31'h0, wbank}, 32'h0);
    wait_done(40, d3);
    check("t3_interval2", 32'(d3 - d2), 32'd10);
    check("t3_wbank3", {31'h0, wbank}, 32'h1);

    // Single event exactly on the tick cycle
    do_reset();
    write_period(32'd20, w);
    wait_until(w + 19);
    count = 8'h20;
    step();
    count = 8'h00;
    wait_done(40, d1);
    check("t4_done_latency", 32'(d1 - w), 32'd29);
    do_read("t4_tick_event", 4'd5, 32'd1);
    do_read("t4_neighbour", 4'd4, 32'd0);
    wait_done(40, d2);
    do_read("t4_next_window", 4'd5, 32'd0);

    // Reads during COPY and on the FLIP cycle see the old bank
    do_reset();
    write_period(32'd20, w);
    count = 8'h01;
    wait_done(40, d1);
    count = 8'h03;
    wait_until(w + 40);
    check("t5_busy_copy", {31'h0, busy}, 32'h1);
    do_read("t5_copy_ch1", 4'd1, 32'd0);
    do_read("t5_copy_ch0", 4'd0, 32'd20);
    wait_until(w + 48);
    do_read("t5_flip_ch1", 4'd1, 32'd0);
    check("t5_flip_done", {31'h0, done}, 32'h1);
    do_read("t5_new_ch1", 4'd1, 32'd11);
    do_read("t5_new_ch0", 4'd0, 32'd20);

    // Reset in the middle of COPY
    do_reset();
    write_period(32'd20, w);
    count = 8'h01;
    wait_done(40, d1);
    do_read("t6_pre", 4'd0, 32'd20);
    wait_until(w + 43);
    check("t6_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_dat", dat, 32'h0);
    check("t6_rst_flags", {28'h0, valid, done, busy, wbank}, 32'h0);
    count = 8'h00;
    step();
    step();
    check("t6_no_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    repeat (4) step();
    do_read("t6_after_rst", 4'd0, 32'd0);
    repeat (20) step();
    check("t6_no_done_idle", {31'h0, done}, 32'h0);
    do_read("t6_still_invalid", 4'd0, 32'd0);
    write_period(32'd20, w);
    count = 8'h01;
    wait_done(40, d1);
    do_read("t6_recovered", 4'd0, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
